// File: rtl/multi_debounce.sv
// Multi-channel push-button debouncer: 2-FF synchroniser, tick-driven stability counter, rise/fall strobes.
// Optional long-press strobe per channel when MULTI_DEBOUNCE_LONG_PRESS_EN is defined.

module multi_debounce_lane #(
    parameter int STABLE_CNT = 1024,
    parameter bit INIT_LEVEL = 1'b0
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
    ,
    parameter int LONG_CNT   = 4096
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic button_in,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = button_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any return to the accepted level cancels the pending change, tick or not.
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (sample_tick) begin
            if (cnt_q == CNT_MAX) begin
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= INIT_LEVEL;
            sync2_q <= INIT_LEVEL;
            db_q    <= INIT_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CNT + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CNT);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              fired_q, fired_d;
    logic              long_press_q, long_press_d;

    always_comb begin
        long_cnt_d   = long_cnt_q;
        fired_d      = fired_q;
        long_press_d = 1'b0;
        if (!db_q) begin
            long_cnt_d = '0;
            fired_d    = 1'b0;
        end else if (sample_tick && long_cnt_q != LONG_MAX) begin
            long_cnt_d = long_cnt_q + LONG_W'(1);
        end
        // Fired flag limits the strobe to once per press while the count sits saturated.
        if (db_q && long_cnt_d == LONG_MAX && !fired_q) begin
            long_press_d = 1'b1;
            fired_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            long_cnt_q   <= '0;
            fired_q      <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            fired_q      <= fired_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

module multi_debounce #(
    parameter int CHANNELS   = 4,
    parameter int STABLE_CNT = 1024,
    parameter bit INIT_LEVEL = 1'b0,
    parameter int LONG_CNT   = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change,
    output logic [CHANNELS-1:0] long_press
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_debounce: CHANNELS must be >= 1");
    end
    if (STABLE_CNT < 2) begin : g_bad_stable_cnt
        $error("multi_debounce: STABLE_CNT must be >= 2");
    end
    if (LONG_CNT < 1) begin : g_bad_long_cnt
        $error("multi_debounce: LONG_CNT must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        multi_debounce_lane #(
            .STABLE_CNT (STABLE_CNT),
            .INIT_LEVEL (INIT_LEVEL)
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
            ,
            .LONG_CNT   (LONG_CNT)
`endif
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .sample_tick (sample_tick),
            .button_in   (button_in[i]),
            .db_out      (db_out[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .long_press  (long_press[i])
        );
    end

    // Strobes are already registered, so this stays aligned with them.
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: directed scenarios plus random stimulus against a tick-counting model.
// Long-press expectations follow MULTI_DEBOUNCE_LONG_PRESS_EN.

module tb_multi_debounce;

    localparam int CH     = 4;
    localparam int STABLE = 4;
    localparam int LONG   = 8;
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_tick = 1'b0;
    logic [CH-1:0] button_in = '0;
    logic [CH-1:0] db_out, rise, fall, long_press;
    logic          any_change;

    int total = 0;
    int bad   = 0;

    multi_debounce #(
        .CHANNELS   (CH),
        .STABLE_CNT (STABLE),
        .INIT_LEVEL (1'b0),
        .LONG_CNT   (LONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .button_in   (button_in),
        .db_out      (db_out),
        .rise        (rise),
        .fall        (fall),
        .any_change  (any_change),
        .long_press  (long_press)
    );

    always #5 clk = ~clk;

    // Reference: the synchronised input is the raw input two edges late; a channel accepts a new
    // level once the synchronised input has disagreed with the accepted level for STABLE ticks in a row.
    logic [CH-1:0] m_p1, m_p2, m_db, m_rise, m_fall, m_lp;
    int            m_ticks_diff [CH];
    int            m_ticks_held [CH];

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_db = '0;
        m_rise = '0; m_fall = '0; m_lp = '0;
        for (int i = 0; i < CH; i++) begin
            m_ticks_diff[i] = 0;
            m_ticks_held[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [CH-1:0] b, input logic t);
        logic [CH-1:0] seen, acc;
        seen = m_p2;
        acc  = m_db;
        m_rise = '0; m_fall = '0; m_lp = '0;
        for (int i = 0; i < CH; i++) begin
            if (seen[i] == acc[i]) m_ticks_diff[i] = 0;
            else if (t) m_ticks_diff[i] += 1;
            if (m_ticks_diff[i] == STABLE) begin
                m_ticks_diff[i] = 0;
                m_db[i]   = seen[i];
                m_rise[i] = seen[i];
                m_fall[i] = !seen[i];
            end
            if (!acc[i]) m_ticks_held[i] = 0;
            else if (t) begin
                m_ticks_held[i] += 1;
                if (LP_EN && m_ticks_held[i] == LONG) m_lp[i] = 1'b1;
            end
        end
        m_p2 = m_p1;
        m_p1 = b;
    endtask

    task automatic step(input logic [CH-1:0] b, input logic t);
        button_in   = b;
        sample_tick = t;
        @(posedge clk);
        model_edge(b, t);
        #1;
    endtask

    task automatic do_reset(input logic [CH-1:0] b);
        button_in = b;
        reset     = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sample_tick = 1'b1;
        do_reset('0);
        total++;
        if ({db_out, rise, fall, long_press, any_change} !== '0) begin
            bad++;
            $display("FAIL reset_state: got db=%b rise=%b fall=%b lp=%b any=%b, want all 0",
                     db_out, rise, fall, long_press, any_change);
        end
    endtask

    task automatic test_single_press();
        do_reset('0);
        for (int e = 1; e <= 8; e++) begin
            step(4'b0001, 1'b1);
            total++;
            if (db_out[0] !== (e >= 6) || rise[0] !== (e == 6) || fall !== '0 || any_change !== (e == 6)) begin
                bad++;
                $display("FAIL single_press edge %0d: got db0=%b rise0=%b fall=%b any=%b, want db0=%b rise0=%b fall=0000 any=%b",
                         e, db_out[0], rise[0], fall, any_change, e >= 6, e == 6, e == 6);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset('0);
        for (int e = 1; e <= 11; e++) begin
            step((e <= 3) ? 4'b0010 : 4'b0000, 1'b1);
            total++;
            if (db_out[1] !== 1'b0 || rise[1] !== 1'b0) begin
                bad++;
                $display("FAIL bounce edge %0d: got db1=%b rise1=%b, want 0 0", e, db_out[1], rise[1]);
            end
        end
        for (int e = 1; e <= 7; e++) begin
            step(4'b0010, 1'b1);
            total++;
            if (db_out[1] !== (e >= 6) || rise[1] !== (e == 6)) begin
                bad++;
                $display("FAIL bounce_repress edge %0d: got db1=%b rise1=%b, want %b %b",
                         e, db_out[1], rise[1], e >= 6, e == 6);
            end
        end
    endtask

    task automatic test_sparse_tick();
        int rise_edge;
        rise_edge = -1;
        do_reset('0);
        for (int e = 1; e <= 20; e++) begin
            step(4'b0100, (e % 3) == 0);
            if (rise[2] === 1'b1) rise_edge = e;
            total++;
            if ({db_out, rise, fall} !== {m_db, m_rise, m_fall}) begin
                bad++;
                $display("FAIL sparse_tick edge %0d: got db=%b rise=%b fall=%b, want db=%b rise=%b fall=%b",
                         e, db_out, rise, fall, m_db, m_rise, m_fall);
            end
        end
        // Divergence visible from edge 3; ticks on edges 3,6,9,12 -> accepted on edge 12.
        total++;
        if (rise_edge != 12) begin
            bad++;
            $display("FAIL sparse_tick_latency: got rise on edge %0d, want edge 12", rise_edge);
        end
    endtask

    task automatic test_simultaneous();
        do_reset('0);
        for (int e = 1; e <= 7; e++) begin
            step(4'b1001, 1'b1);
            total++;
            if (rise !== ((e == 6) ? 4'b1001 : 4'b0000) || any_change !== (e == 6)) begin
                bad++;
                $display("FAIL simul_rise edge %0d: got rise=%b any=%b, want rise=%b any=%b",
                         e, rise, any_change, (e == 6) ? 4'b1001 : 4'b0000, e == 6);
            end
        end
        for (int e = 1; e <= 7; e++) begin
            step(4'b0000, 1'b1);
            total++;
            if (fall !== ((e == 6) ? 4'b1001 : 4'b0000) || rise !== '0 || any_change !== (e == 6)) begin
                bad++;
                $display("FAIL simul_fall edge %0d: got fall=%b rise=%b any=%b, want fall=%b rise=0000 any=%b",
                         e, fall, rise, any_change, (e == 6) ? 4'b1001 : 4'b0000, e == 6);
            end
        end
    endtask

    task automatic test_reset_midcount();
        do_reset('0);
        for (int e = 1; e <= 4; e++) step(4'b0001, 1'b1);
        sample_tick = 1'b1;
        do_reset(4'b0001);
        total++;
        if ({db_out, rise, fall, any_change} !== '0) begin
            bad++;
            $display("FAIL reset_midcount_state: got db=%b rise=%b fall=%b any=%b, want all 0",
                     db_out, rise, fall, any_change);
        end
        for (int e = 1; e <= 7; e++) begin
            step(4'b0001, 1'b1);
            total++;
            if (db_out[0] !== (e >= 6) || rise[0] !== (e == 6)) begin
                bad++;
                $display("FAIL reset_midcount edge %0d: got db0=%b rise0=%b, want %b %b",
                         e, db_out[0], rise[0], e >= 6, e == 6);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset('0);
        step(4'b1000, 1'b1);
        for (int e = 0; e < 10; e++) begin
            step(4'b0000, 1'b1);
            total++;
            if (db_out !== '0 || rise !== '0) begin
                bad++;
                $display("FAIL glitch cycle %0d: got db=%b rise=%b, want 0000 0000", e, db_out, rise);
            end
        end
    endtask

    task automatic test_long_press();
        int rise_edge, lp_edge, lp_count;
        do_reset('0);
        for (int round = 0; round < 2; round++) begin
            rise_edge = -1; lp_edge = -1; lp_count = 0;
            for (int e = 1; e <= 30; e++) begin
                step(4'b0010, 1'b1);
                if (rise[1] === 1'b1) rise_edge = e;
                if (long_press[1] === 1'b1) begin
                    lp_count++;
                    lp_edge = e;
                end
                total++;
                if (long_press !== m_lp || db_out !== m_db) begin
                    bad++;
                    $display("FAIL long_press_model round %0d edge %0d: got lp=%b db=%b, want lp=%b db=%b",
                             round, e, long_press, db_out, m_lp, m_db);
                end
            end
            total++;
            if (lp_count != (LP_EN ? 1 : 0) || lp_edge != (LP_EN ? rise_edge + LONG : -1)) begin
                bad++;
                $display("FAIL long_press_count round %0d: got %0d pulses at edge %0d (rise %0d), want %0d pulses at edge %0d",
                         round, lp_count, lp_edge, rise_edge, LP_EN ? 1 : 0, LP_EN ? rise_edge + LONG : -1);
            end
            for (int e = 1; e <= 10; e++) step(4'b0000, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] b;
        logic          t;
        b = '0;
        do_reset('0);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
            t = ($urandom_range(0, 2) != 0);
            step(b, t);
            total++;
            if ({db_out, rise, fall, long_press, any_change} !== {m_db, m_rise, m_fall, m_lp, |(m_rise | m_fall)}
                || (rise & fall) !== '0) begin
                bad++;
                $display("FAIL random cycle %0d: got db=%b r=%b f=%b lp=%b any=%b, want db=%b r=%b f=%b lp=%b any=%b",
                         c, db_out, rise, fall, long_press, any_change,
                         m_db, m_rise, m_fall, m_lp, |(m_rise | m_fall));
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_press();
        test_bounce();
        test_sparse_tick();
        test_simultaneous();
        test_reset_midcount();
        test_glitch();
        test_long_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
